// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - alu_op_e    : 4-bit opcode encoding (OP_ADD..OP_MUL; 12-15 are illegal)
//   - FLAG_*      : bit positions inside the 5-bit flags word {err, ovf, carry, neg, zero}
//   - alu_state_e : top-level FSM state (idle / iterative multiply)
//   - pack_flags  : assembles the flags word from individual status bits
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SRA  = 4'd7,
        OP_EQ   = 4'd8,
        OP_SLTU = 4'd9,
        OP_SLT  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_NEG   = 1;
    localparam int unsigned FLAG_CARRY = 2;
    localparam int unsigned FLAG_OVF   = 3;
    localparam int unsigned FLAG_ERR   = 4;
    localparam int unsigned NUM_FLAGS  = 5;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StMul  = 1'b1
    } alu_state_e;

    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic err, input logic ovf,
                                                        input logic carry, input logic neg,
                                                        input logic zero);
        logic [NUM_FLAGS-1:0] f;
        f             = '0;
        f[FLAG_ERR]   = err;
        f[FLAG_OVF]   = ovf;
        f[FLAG_CARRY] = carry;
        f[FLAG_NEG]   = neg;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier.
//   clk, rst : clock and synchronous active-high reset (aborts any multiply in flight)
//   start    : load operands a/b; the multiply then runs for exactly WIDTH cycles
//   a, b     : WIDTH-bit unsigned operands, sampled when start is high
//   done     : high in the last of the WIDTH busy cycles
//   product  : full 2*WIDTH-bit product, valid while done is high
//
// One multiplier bit is retired per cycle. The product is exposed as the
// accumulator's next value so the caller can capture it on the same edge
// the last partial product is added, without an extra cycle of latency.
module alu_mul_seq import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

    logic               busy_q;
    logic [SHW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;

    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == LastCnt);
    assign product = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: parametrised ALU with valid/ready handshake on both sides.
//   clk, rst   : clock (rising edge) and synchronous active-high reset
//   in_valid   : operands/opcode valid          in_ready : block can accept this cycle
//   A, B       : operands; B[SHW-1:0] is the shift amount for shift ops
//   ALU_ctrl   : opcode (see alu_pkg::alu_op_e; 12-15 illegal)
//   out_valid  : result/flags valid             out_ready: consumer accepts
//   result     : registered result
//   flags      : registered {err, ovf, carry, neg, zero}
//
// Single-cycle ops are computed combinationally and registered on accept.
// MUL hands off to alu_mul_seq and the FSM sits in StMul until it finishes.
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int MSB = WIDTH - 1;

    alu_state_e state;
    logic       accept;
    logic       is_mul;

    logic [SHW-1:0] shamt;

    // One spare bit on each side captures carry/borrow or the last bit shifted out.
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic [WIDTH:0] shl_w;
    logic [WIDTH:0] shr_w;
    logic [WIDTH:0] sra_w;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic [4:0]       alu_flags;

    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [4:0]         mul_flags;

    assign in_ready = (state == StIdle) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (ALU_ctrl == OP_MUL);
    assign shamt    = B[SHW-1:0];

    always_comb begin
        add_w = {1'b0, A} + {1'b0, B};
        sub_w = {1'b0, A} - {1'b0, B};
        shl_w = {1'b0, A} << shamt;
        shr_w = {A, 1'b0} >> shamt;
        sra_w = $signed({A, 1'b0}) >>> shamt;

        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;

        case (ALU_ctrl)
            OP_ADD: begin
                alu_res   = add_w[WIDTH-1:0];
                alu_carry = add_w[WIDTH];
                alu_ovf   = (A[MSB] == B[MSB]) && (add_w[MSB] != A[MSB]);
            end
            OP_SUB: begin
                alu_res   = sub_w[WIDTH-1:0];
                alu_carry = sub_w[WIDTH];
                alu_ovf   = (A[MSB] != B[MSB]) && (sub_w[MSB] != A[MSB]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SHL: begin
                alu_res   = shl_w[WIDTH-1:0];
                alu_carry = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res   = shr_w[WIDTH:1];
                alu_carry = shr_w[0];
            end
            OP_SRA: begin
                alu_res   = sra_w[WIDTH:1];
                alu_carry = sra_w[0];
            end
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (A == B)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            // MUL result comes from the sequential multiplier, not this path.
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase

        alu_flags = pack_flags(alu_err, alu_ovf, alu_carry, alu_res[MSB], (alu_res == '0));
        mul_flags = pack_flags(1'b0, 1'b0, (mul_prod[2*WIDTH-1:WIDTH] != '0),
                               mul_prod[MSB], (mul_prod[WIDTH-1:0] == '0));
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            // Drain first; a same-cycle accept below overwrites the register.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= StMul;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            flags     <= alu_flags;
                        end
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        state     <= StIdle;
                        out_valid <= 1'b1;
                        result    <= mul_prod[WIDTH-1:0];
                        flags     <= mul_flags;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed vectors with literal expectations plus
// a scoreboard fed by an arithmetic model of the opcode rules.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [3:0] ALU_ctrl = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic [4:0] flags;

    int n_cmp = 0;
    int n_bad = 0;

    alu_pipe #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_ctrl  (ALU_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {result[7:0], err, ovf, carry, neg, zero} from the opcode rules.
    function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int ua, ub, sa, sb, s, r, c, o, e, full;
        logic [7:0] rr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        s  = ub % 8;
        r = 0; c = 0; o = 0; e = 0;
        case (op)
            4'd0: begin
                full = ua + ub; r = full % 256; c = (full > 255) ? 1 : 0;
                o = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
            end
            4'd1: begin
                r = (ua - ub + 256) % 256; c = (ua < ub) ? 1 : 0;
                o = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: begin r = (ua << s) % 256; c = (s == 0) ? 0 : (ua >> (8 - s)) & 1; end
            4'd6: begin r = ua >> s; c = (s == 0) ? 0 : (ua >> (s - 1)) & 1; end
            4'd7: begin r = (sa >>> s) & 255; c = (s == 0) ? 0 : (sa >>> (s - 1)) & 1; end
            4'd8: r = (ua == ub) ? 1 : 0;
            4'd9: r = (ua < ub) ? 1 : 0;
            4'd10: r = (sa < sb) ? 1 : 0;
            4'd11: begin full = ua * ub; r = full % 256; c = (full > 255) ? 1 : 0; end
            default: begin r = 0; e = 1; end
        endcase
        rr = r[7:0];
        return {rr, e[0], o[0], c[0], (r >= 128), (r == 0)};
    endfunction

    // Scoreboard and hold check, sampled mid-cycle.
    logic [12:0] exp_q[$];
    logic        stall = 1'b0;
    logic [12:0] held = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                stall = 1'b0;
            end else begin
                if (stall && out_valid) chk("hold_stable", int'({result, flags}), int'(held));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("spurious_output", exp_q.size(), 1);
                    else chk("scoreboard", int'({result, flags}), int'(exp_q.pop_front()));
                end
                if (in_valid && in_ready) exp_q.push_back(model(ALU_ctrl, A, B));
                stall = out_valid && !out_ready;
                held  = {result, flags};
            end
        end
    end

    // Presents one op and returns #1 after the edge that accepted it.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        ALU_ctrl = op;
        A = a;
        B = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic [4:0] ef);
        issue(op, a, b);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_result"}, int'(result), int'(er));
        chk({name, "_flags"}, int'(flags), int'(ef));
    endtask

    logic rand_done = 1'b0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_flags", int'(flags), 0);
        chk("reset_in_ready", int'(in_ready), 1);

        // flags = {err, ovf, carry, neg, zero}
        run_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 5'b00101);
        run_op("add_7f_01", 4'd0, 8'h7F, 8'h01, 8'h80, 5'b01010);
        run_op("sub_80_01", 4'd1, 8'h80, 8'h01, 8'h7F, 5'b01000);
        run_op("slt_80_01", 4'd10, 8'h80, 8'h01, 8'h01, 5'b00000);
        run_op("sltu_80_01", 4'd9, 8'h80, 8'h01, 8'h00, 5'b00001);
        run_op("sra_90_02", 4'd7, 8'h90, 8'h02, 8'hE4, 5'b00010);
        run_op("shl_81_09", 4'd5, 8'h81, 8'h09, 8'h02, 5'b00100);
        run_op("shr_amt0", 4'd6, 8'hA5, 8'h08, 8'hA5, 5'b00010);
        run_op("eq_5a_5a", 4'd8, 8'h5A, 8'h5A, 8'h01, 5'b00000);
        run_op("illegal_f", 4'hF, 8'h12, 8'h34, 8'h00, 5'b10001);

        // MUL latency: busy for 8 cycles, result in the 9th.
        issue(4'd11, 8'h10, 8'h11);
        for (int k = 0; k < 8; k++) begin
            chk("mul_in_ready_low", int'(in_ready), 0);
            chk("mul_no_early_out", int'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        chk("mul_10_11_valid", int'(out_valid), 1);
        chk("mul_10_11_result", int'(result), 8'h10);
        chk("mul_10_11_flags", int'(flags), 5'b00100);
        issue(4'd11, 8'h00, 8'hFF);
        repeat (8) @(posedge clk);
        #1;
        chk("mul_00_ff_result", int'(result), 8'h00);
        chk("mul_00_ff_flags", int'(flags), 5'b00001);
        @(posedge clk);
        #1;

        // Backpressure: first result held 3 cycles while the next ADD waits.
        out_ready = 1'b0;
        issue(4'd0, 8'h10, 8'h20);
        in_valid = 1'b1;
        A = 8'h01;
        B = 8'h02;
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready_low", int'(in_ready), 0);
            chk("bp_result_held", int'(result), 8'h30);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_accept_on_drain", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("bp_second_result", int'(result), 8'h03);
        A = 8'hF0;
        B = 8'h20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_third_result", int'(result), 8'h10);
        chk("bp_third_flags", int'(flags), 5'b00100);
        @(posedge clk);
        #1;

        // Reset four cycles into a MUL: nothing may emerge afterwards.
        issue(4'd11, 8'h07, 8'h09);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mul_out_valid", int'(out_valid), 0);
        chk("rst_mul_in_ready", int'(in_ready), 1);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) chk("rst_mul_no_result", int'(out_valid), 0);
        end

        // Mixed ops under random backpressure, checked by the scoreboard.
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
